// File: rtl/fsub_retire_if.sv
// Issue/retire bundle between an fsub pipeline controller and fsub_retire.
// The master side issues ops, drives the fsub result and consumes retired
// results; the slave side is the retire block itself.
interface fsub_retire_if #(
  parameter int TAGW = 5
);
  logic            flush;
  logic            in_valid;
  logic [TAGW-1:0] in_tag;
  logic            in_ready;
  logic [31:0]     y;
  logic            ovf;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_data;
  logic            out_ovf;
  logic [TAGW-1:0] out_tag;

  modport master (
    output flush, in_valid, in_tag, y, ovf, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_tag
  );

  modport slave (
    input  flush, in_valid, in_tag, y, ovf, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_tag
  );
endinterface

// File: rtl/fsub_retire.sv
// Retire stage for a fixed-latency fsub unit.
// Issued ops are tracked by a valid+tag shift register as deep as the fsub
// pipeline; when a tracked op reaches the end, the fsub result is captured
// with its tag into a small FIFO that writeback drains. Issue is throttled
// so that every op in flight is guaranteed a FIFO slot when it lands.
module fsub_retire #(
  parameter int NSTAGE = 2,
  parameter int DEPTH  = 4,
  parameter int TAGW   = 5
) (
  input logic         clk,
  input logic         rst,
  fsub_retire_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(NSTAGE + 1);
  localparam int SW = $clog2(DEPTH + NSTAGE + 1);
  localparam int EW = 32 + 1 + TAGW;

  logic [NSTAGE-1:0] slot_vld;
  logic [TAGW-1:0]   slot_tag [NSTAGE];
  logic [EW-1:0]     mem [DEPTH];
  logic [EW-1:0]     head;
  logic [AW-1:0]     rptr;
  logic [AW-1:0]     wptr;
  logic [CW-1:0]     count;
  logic [IW-1:0]     inflight;
  logic              accept;
  logic              fifo_wr;
  logic              fifo_rd;

  // Number of issued ops still travelling through the fsub pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      inflight = inflight + IW'(slot_vld[i]);
    end
  end

  // Issue is only allowed while queued plus in-flight results leave room in
  // the FIFO; a pop in the same cycle does not count, keeping this purely a
  // function of registered state. Flush and reset both close the gate.
  assign bus.in_ready = !rst && !bus.flush &&
                        ((SW'(count) + SW'(inflight)) < SW'(DEPTH));
  assign accept  = bus.in_valid & bus.in_ready;
  assign fifo_wr = slot_vld[NSTAGE-1] & !bus.flush;
  assign fifo_rd = bus.out_valid & bus.out_ready & !bus.flush;

  assign head          = mem[rptr];
  assign bus.out_valid = (count != '0);
  assign bus.out_data  = bus.out_valid ? head[EW-1 -: 32] : 32'h0;
  assign bus.out_ovf   = bus.out_valid ? head[TAGW] : 1'b0;
  assign bus.out_tag   = bus.out_valid ? head[TAGW-1:0] : '0;

  // Shift register mirrors the fsub pipeline, advancing every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_vld <= '0;
      for (int i = 0; i < NSTAGE; i++) begin
        slot_tag[i] <= '0;
      end
    end else begin
      if (bus.flush) begin
        slot_vld <= '0;
      end else begin
        slot_vld[0] <= accept;
        for (int i = 1; i < NSTAGE; i++) begin
          slot_vld[i] <= slot_vld[i-1];
        end
      end
      slot_tag[0] <= bus.in_tag;
      for (int i = 1; i < NSTAGE; i++) begin
        slot_tag[i] <= slot_tag[i-1];
      end
    end
  end

  // Capture the landing fsub result together with its tag.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem[wptr] <= {bus.y, bus.ovf, slot_tag[NSTAGE-1]};
    end
  end

  // FIFO pointers and occupancy; write and pop together leave count as is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (bus.flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (fifo_wr) begin
        wptr <= wptr + AW'(1);
      end
      if (fifo_rd) begin
        rptr <= rptr + AW'(1);
      end
      count <= count + CW'(fifo_wr) - CW'(fifo_rd);
    end
  end

  // A landing result must always find a free FIFO slot.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(fifo_wr && (count == CW'(DEPTH))))
        else $error("fsub_retire: result written into a full FIFO");
    end
  end
endmodule

// File: tb/tb_fsub_retire.sv
// Bench for fsub_retire: directed stimulus, a queue-based reference model
// checked every cycle, plus hand-computed expectations at key points.
module tb_fsub_retire;
  localparam int NSTAGE = 2;
  localparam int DEPTH  = 4;
  localparam int TAGW   = 5;

  logic clk;
  logic rst;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [TAGW-1:0] tag;
    int              due;
  } pend_t;

  typedef struct {
    logic [31:0]     data;
    logic            ovf;
    logic [TAGW-1:0] tag;
  } res_t;

  pend_t pend_q[$];
  res_t  res_q[$];

  fsub_retire_if #(.TAGW(TAGW)) bus ();

  fsub_retire #(
    .NSTAGE(NSTAGE),
    .DEPTH (DEPTH),
    .TAGW  (TAGW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] junk();
    return 32'hDEAD0000 ^ 32'(cyc * 37);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: results are a queue in issue order; an issued op owns
  // whatever y/ovf is on the bus NSTAGE cycles later and then joins the
  // retire queue. Checked at mid-cycle, then advanced to the next edge.
  task automatic modelStep();
    logic  m_ready;
    pend_t p;
    res_t  r;
    if (rst) begin
      pend_q.delete();
      res_q.delete();
      checkOutput("rst_in_ready",  32'(bus.in_ready),  32'h0);
      checkOutput("rst_out_valid", 32'(bus.out_valid), 32'h0);
      checkOutput("rst_out_data",  bus.out_data,       32'h0);
      checkOutput("rst_out_ovf",   32'(bus.out_ovf),   32'h0);
      checkOutput("rst_out_tag",   32'(bus.out_tag),   32'h0);
    end else begin
      m_ready = !bus.flush && ((res_q.size() + pend_q.size()) < DEPTH);
      checkOutput("model_in_ready",  32'(bus.in_ready),  32'(m_ready));
      checkOutput("model_out_valid", 32'(bus.out_valid), 32'(res_q.size() != 0));
      if (res_q.size() != 0) begin
        checkOutput("model_out_data", bus.out_data,      res_q[0].data);
        checkOutput("model_out_ovf",  32'(bus.out_ovf),  32'(res_q[0].ovf));
        checkOutput("model_out_tag",  32'(bus.out_tag),  32'(res_q[0].tag));
      end
      if (bus.flush) begin
        pend_q.delete();
        res_q.delete();
      end else begin
        if (res_q.size() != 0 && bus.out_ready) begin
          void'(res_q.pop_front());
        end
        if (pend_q.size() != 0 && pend_q[0].due == cyc) begin
          r.data = bus.y;
          r.ovf  = bus.ovf;
          r.tag  = pend_q[0].tag;
          res_q.push_back(r);
          void'(pend_q.pop_front());
        end
        if (bus.in_valid && m_ready) begin
          p.tag = bus.in_tag;
          p.due = cyc + NSTAGE;
          pend_q.push_back(p);
        end
      end
    end
    cyc++;
  endtask

  // Drive one cycle of inputs just after the edge, then check at mid-cycle.
  task automatic applyStimulus(input logic r, input logic v,
                               input logic [TAGW-1:0] t, input logic [31:0] yv,
                               input logic ov, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    rst           = r;
    bus.in_valid  = v;
    bus.in_tag    = t;
    bus.y         = yv;
    bus.ovf       = ov;
    bus.out_ready = ordy;
    bus.flush     = fl;
    @(negedge clk);
    modelStep();
  endtask

  // Directed sequence.
  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_tag    = '0;
    bus.y         = 32'h0;
    bus.ovf       = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;

    // Reset held, with garbage on the inputs.
    applyStimulus(1, 1, 5'd17, junk(), 1, 1, 0);
    applyStimulus(1, 1, 5'd18, junk(), 1, 0, 0);
    applyStimulus(0, 0, 5'd0, junk(), 0, 1, 0);
    checkOutput("rst_release_ready", 32'(bus.in_ready), 32'h1);

    // Single issue, latency NSTAGE+1.
    $display("[TB] single issue");
    applyStimulus(0, 1, 5'd3, junk(), 0, 1, 0);
    checkOutput("t1_issue_ready", 32'(bus.in_ready), 32'h1);
    applyStimulus(0, 0, 5'd0, junk(), 1, 1, 0);
    checkOutput("t1_c1_valid", 32'(bus.out_valid), 32'h0);
    applyStimulus(0, 0, 5'd0, 32'h40400000, 0, 1, 0);
    checkOutput("t1_c2_valid", 32'(bus.out_valid), 32'h0);
    applyStimulus(0, 0, 5'd0, junk(), 1, 1, 0);
    checkOutput("t1_c3_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("t1_c3_data",  bus.out_data,       32'h40400000);
    checkOutput("t1_c3_tag",   32'(bus.out_tag),   32'h3);
    checkOutput("t1_c3_ovf",   32'(bus.out_ovf),   32'h0);
    applyStimulus(0, 0, 5'd0, junk(), 0, 1, 0);
    checkOutput("t1_c4_valid", 32'(bus.out_valid), 32'h0);

    // Back-to-back issue with writeback always ready.
    $display("[TB] back-to-back");
    for (int j = 0; j < 13; j++) begin
      applyStimulus(0, j < 10, TAGW'(j), 32'h3F800000 + 32'(j), 0, 1, 0);
      if (j < 10) checkOutput("t2_in_ready", 32'(bus.in_ready), 32'h1);
      if (j >= 3) begin
        checkOutput("t2_out_valid", 32'(bus.out_valid), 32'h1);
        checkOutput("t2_out_tag",   32'(bus.out_tag),   32'(j - 3));
        checkOutput("t2_out_data",  bus.out_data,       32'h3F800000 + 32'(j - 1));
      end
    end
    applyStimulus(0, 0, 5'd0, junk(), 0, 1, 0);
    checkOutput("t2_drained", 32'(bus.out_valid), 32'h0);

    // Backpressure: only DEPTH ops accepted, then an in-order drain.
    $display("[TB] backpressure");
    for (int j = 0; j < 8; j++) begin
      applyStimulus(0, 1, TAGW'(10 + j), 32'h40000000 + 32'(j), 0, 0, 0);
      checkOutput("t3_in_ready", 32'(bus.in_ready), 32'(j < 4));
    end
    checkOutput("t3_full_valid", 32'(bus.out_valid), 32'h1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 5'd0, junk(), 0, 1, 0);
      if (k == 0) checkOutput("t3_pop_no_ready", 32'(bus.in_ready), 32'h0);
      checkOutput("t3_drain_tag",  32'(bus.out_tag), 32'(10 + k));
      checkOutput("t3_drain_data", bus.out_data,     32'h40000000 + 32'(k + 2));
    end
    applyStimulus(0, 0, 5'd0, junk(), 0, 1, 0);
    checkOutput("t3_empty", 32'(bus.out_valid), 32'h0);

    // Overflow flag travels only with its own result.
    $display("[TB] overflow passthrough");
    for (int j = 0; j < 6; j++) begin
      applyStimulus(0, j < 3, TAGW'(6 + j), 32'h41000000 + 32'(j),
                    (j == 3) || (j == 1), 1, 0);
      if (j >= 3) begin
        checkOutput("t4_tag", 32'(bus.out_tag), 32'(6 + j - 3));
        checkOutput("t4_ovf", 32'(bus.out_ovf), 32'(j == 4));
      end
    end
    applyStimulus(0, 0, 5'd0, junk(), 0, 1, 0);

    // Flush with two queued and two in flight.
    $display("[TB] flush");
    for (int j = 0; j < 4; j++) begin
      applyStimulus(0, 1, TAGW'(20 + j), 32'h42000000 + 32'(j), 0, 0, 0);
    end
    applyStimulus(0, 1, 5'd24, 32'h4BAD0004, 0, 1, 1);
    checkOutput("t5_flush_ready", 32'(bus.in_ready),  32'h0);
    checkOutput("t5_flush_valid", 32'(bus.out_valid), 32'h1);
    for (int j = 5; j < 8; j++) begin
      applyStimulus(0, 0, 5'd0, 32'h4BAD0000 + 32'(j), 1, 1, 0);
      if (j == 5) checkOutput("t5_after_ready", 32'(bus.in_ready), 32'h1);
      checkOutput("t5_after_valid", 32'(bus.out_valid), 32'h0);
    end

    // Flush on an otherwise empty block with an issue attempt.
    applyStimulus(0, 1, 5'd26, junk(), 0, 1, 1);
    checkOutput("t5b_flush_ready", 32'(bus.in_ready), 32'h0);
    for (int j = 0; j < 4; j++) begin
      applyStimulus(0, 0, 5'd0, junk(), 0, 1, 0);
      checkOutput("t5b_no_ghost", 32'(bus.out_valid), 32'h0);
    end
    applyStimulus(0, 1, 5'd25, junk(), 0, 1, 0);
    applyStimulus(0, 0, 5'd0, junk(), 0, 1, 0);
    applyStimulus(0, 0, 5'd0, 32'h42424242, 0, 1, 0);
    applyStimulus(0, 0, 5'd0, junk(), 0, 1, 0);
    checkOutput("t5b_fresh_tag",  32'(bus.out_tag), 32'd25);
    checkOutput("t5b_fresh_data", bus.out_data,     32'h42424242);
    applyStimulus(0, 0, 5'd0, junk(), 0, 1, 0);

    // Reset mid-operation with three results queued.
    $display("[TB] mid-run reset");
    for (int j = 0; j < 6; j++) begin
      applyStimulus(0, j < 3, TAGW'(1 + j), 32'h43000000 + 32'(j), 0, 0, 0);
    end
    checkOutput("t6_pre_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("t6_pre_tag",   32'(bus.out_tag),   32'h1);
    applyStimulus(1, 1, 5'd30, junk(), 0, 0, 0);
    checkOutput("t6_rst_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("t6_rst_ready", 32'(bus.in_ready),  32'h0);
    checkOutput("t6_rst_data",  bus.out_data,       32'h0);
    applyStimulus(1, 0, 5'd0, junk(), 0, 1, 0);
    applyStimulus(0, 0, 5'd0, junk(), 0, 1, 0);
    checkOutput("t6_release_ready", 32'(bus.in_ready), 32'h1);
    applyStimulus(0, 1, 5'd9, junk(), 0, 1, 0);
    applyStimulus(0, 0, 5'd0, junk(), 0, 1, 0);
    applyStimulus(0, 0, 5'd0, 32'h12345678, 0, 1, 0);
    checkOutput("t6_no_early", 32'(bus.out_valid), 32'h0);
    applyStimulus(0, 0, 5'd0, junk(), 0, 1, 0);
    checkOutput("t6_fresh_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("t6_fresh_tag",   32'(bus.out_tag),   32'd9);
    checkOutput("t6_fresh_data",  bus.out_data,       32'h12345678);
    applyStimulus(0, 0, 5'd0, junk(), 0, 1, 0);
    checkOutput("t6_final_empty", 32'(bus.out_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fsub_retire.md
FSUB_RETIRE -- requirements
Module: fsub_retire

Interface
REQ-001 SHALL have parameter NSTAGE, default 2, fsub pipeline latency in cycles (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, result FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter TAGW, default 5, destination tag width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  synchronous discard of all queued and in-flight results.
REQ-007 SHALL have port in_valid  input  1  issue request; operands are on fsub x1/x2 in the same cycle.
REQ-008 SHALL have port in_tag  input  TAGW  destination tag of the issued op.
REQ-009 SHALL have port in_ready  output  1  issue permitted; handshake = in_valid & in_ready.
REQ-010 SHALL have port y  input  32  fsub result.
REQ-011 SHALL have port ovf  input  1  fsub overflow flag.
REQ-012 SHALL have port out_valid  output  1  FIFO head valid.
REQ-013 SHALL have port out_ready  input  1  writeback accepts head; pop = out_valid & out_ready.
REQ-014 SHALL have port out_data  output  32  head result.
REQ-015 SHALL have port out_ovf  output  1  head overflow flag.
REQ-016 SHALL have port out_tag  output  TAGW  head tag.

Function
REQ-017 SHALL track each handshake in an NSTAGE-deep valid+tag shift register advancing every cycle, unconditionally.
REQ-018 SHALL treat y/ovf as belonging to an issue handshake in cycle c during cycle c+NSTAGE, and SHALL write {y, ovf, tag} into the FIFO at the end of that cycle.
REQ-019 SHALL present a result on out_* no earlier than cycle c+NSTAGE+1 (latency NSTAGE+1 cycles with empty FIFO).
REQ-020 SHALL keep inflight = number of valid shift-register slots (0..NSTAGE) and count = FIFO occupancy (0..DEPTH).
REQ-021 SHALL drive in_ready = (count + inflight) < DEPTH, from registered state only; a same-cycle pop SHALL NOT raise in_ready.
REQ-022 SHALL never drop a result: by REQ-021 a FIFO write SHALL never find the FIFO full; an assertion SHALL flag the condition.
REQ-023 SHALL support simultaneous FIFO write and pop in one cycle, count unchanged, including at count = 1 (no bubble or overwrite).
REQ-024 SHALL drive out_valid = (count != 0); out_data/out_ovf/out_tag SHALL be stable while out_valid & !out_ready.
REQ-025 SHALL preserve issue order: results leave in handshake order.
REQ-026 SHALL wrap read/write pointers modulo DEPTH.
REQ-027 SHALL, on flush, clear all shift-register valid bits and empty the FIFO at the next edge; a handshake or pop in the flush cycle SHALL be discarded; in_ready SHALL be 0 during the flush cycle.
REQ-028 SHALL ignore in_tag, y, ovf when not qualified by a valid slot.

Reset
REQ-029 SHALL, while rst is high, force in_ready=0, out_valid=0, out_data=0, out_ovf=0, out_tag=0, count=0, inflight=0, pointers=0.
REQ-030 SHALL assert in_ready in the first cycle after rst deasserts.
REQ-031 SHALL, when rst asserts mid-operation, discard all in-flight and queued results immediately (asynchronously).

Verification
REQ-032 Single issue, NSTAGE=2: handshake cycle 0 tag=3, y=0x40400000 in cycle 2 -> out_valid in cycle 3, out_data=0x40400000, out_tag=3, out_ovf=0.
REQ-033 Back-to-back issue with out_ready=1: tags 0..9 over 10 cycles -> in_ready stays 1, outputs tags 0..9 in order, one per cycle from cycle 3.
REQ-034 Backpressure, DEPTH=4, out_ready=0: continuous in_valid -> exactly 4 handshakes accepted, in_ready 0 afterwards, count reaches 4, no loss; out_ready=1 then drains 4 in order.
REQ-035 Overflow passthrough: ovf=1 aligned with tag 7 -> out_ovf=1 only on the tag 7 entry.
REQ-036 Flush with 2 in flight and 2 queued -> next cycle out_valid=0, in_ready=1, stale y values never appear on out_*.
REQ-037 rst pulsed high with FIFO count=3 -> out_valid=0 immediately; after release, a fresh issue returns with latency 3.
